// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: req/ack fetch engine feeding a DEPTH-entry {pc, word} FIFO
// presented to the decoder via valid/ready. Define IFQ_BYPASS_EN for an empty-queue bypass.
`timescale 1ns/1ps

module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StWait} req_state_e;

  req_state_e      state_q;
  logic [31:0]     pc_q;
  logic [31:0]     addr_q;
  logic            discard_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic            valid_q;
  logic [31:0]     mem_pc_q   [DEPTH];
  logic [31:0]     mem_word_q [DEPTH];

  logic ack_fire;
  logic push;
  logic pop_fifo;
  logic bypass_take;
  logic space_left;

  assign ack_fire = (state_q == StWait) && imem_ack_i;
  assign pop_fifo = valid_q && instr_ready_i && !flush_i;

`ifdef IFQ_BYPASS_EN
  logic bypass;

  // An acked word arriving at an empty queue is shown to the decoder in the same cycle.
  assign bypass        = ack_fire && !discard_q && !flush_i && (count_q == '0);
  assign bypass_take   = bypass && instr_ready_i;
  assign instr_valid_o = valid_q || bypass;
  assign instruction_o = bypass ? imem_rdata_i : mem_word_q[rd_ptr_q];
  assign instr_pc_o    = bypass ? addr_q : mem_pc_q[rd_ptr_q];
`else
  assign bypass_take   = 1'b0;
  assign instr_valid_o = valid_q;
  assign instruction_o = mem_word_q[rd_ptr_q];
  assign instr_pc_o    = mem_pc_q[rd_ptr_q];
`endif

  assign push = ack_fire && !discard_q && !flush_i && !bypass_take;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push && !pop_fifo) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop_fifo) begin
      count_d = count_q - 1'b1;
    end
  end

  // A new request is only issued when its word is guaranteed a slot.
  assign space_left = (count_d < CntW'(DEPTH));

  assign imem_req_o  = (state_q == StWait);
  assign imem_addr_o = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      mem_pc_q   <= '{default: '0};
      mem_word_q <= '{default: '0};
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_pc_q[wr_ptr_q]   <= addr_q;
          mem_word_q[wr_ptr_q] <= imem_rdata_i;
          wr_ptr_q             <= wr_ptr_q + 1'b1;
        end
        if (pop_fifo) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // addr_q is the address on the bus; pc_q is the next address to fetch. They differ only
  // while a pre-flush request is still waiting for its (discarded) ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            pc_q   <= flush_pc_i;
            addr_q <= flush_pc_i;
          end
          if (space_left) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (imem_ack_i) begin
            discard_q <= 1'b0;
            if (flush_i) begin
              pc_q   <= flush_pc_i;
              addr_q <= flush_pc_i;
            end else if (discard_q) begin
              addr_q <= pc_q;
            end else begin
              pc_q   <= pc_q + 32'd4;
              addr_q <= pc_q + 32'd4;
            end
            state_q <= space_left ? StWait : StIdle;
          end else if (flush_i) begin
            pc_q      <= flush_pc_i;
            discard_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  addr_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req_o && !imem_ack_i |=> imem_req_o && $stable(imem_addr_o));

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    push && !pop_fifo |-> count_q < CntW'(DEPTH));

  count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CntW'(DEPTH));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue (default build): directed table, corner
// sequences, and randomized traffic against a queue-level reference model.
`timescale 1ns/1ps

module tb_instruction_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instruction_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .flush_i      (flush),
    .flush_pc_i   (flush_pc),
    .instr_valid_o(instr_valid),
    .instruction_o(instruction),
    .instr_pc_o   (instr_pc),
    .instr_ready_i(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; memory returns the word for whatever address is on the bus.
  task automatic step(input bit ack, input bit rdy, input bit fl, input logic [31:0] fpc);
    imem_ack    = ack;
    imem_rdata  = word_of(imem_addr);
    instr_ready = rdy;
    flush       = fl;
    flush_pc    = fpc;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset check, then release; returns sampling the first cycle after release.
  task automatic do_reset();
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    rst_n       = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          ack;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [16];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_hold_addr;
  logic [31:0] m_addr;
  bit          m_discard;
  bit          m_held;
  bit          m_req;
  bit          m_valid;

  initial begin
    rst_n = 1'b1;

    // Fill with ack tied high and the decoder stalled, then drain with one-pop refills.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h04};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h18};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h1C};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h00};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_word", i), instruction, word_of(tbl[i].e_pc));
      end
      step(tbl[i].ack, tbl[i].rdy, 1'b0, 32'h0);
    end

    // Flush while a slow request to 0x8 is outstanding: its word is discarded.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("fw_addr8", imem_addr, 32'h8);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    chk("fw_req_held", 32'(imem_req), 32'd1);
    chk("fw_addr_held", imem_addr, 32'h8);
    chk("fw_valid0", 32'(instr_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fw_addr_held2", imem_addr, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fw_newaddr", imem_addr, 32'h100);
    chk("fw_nopush", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fw_first_pc", instr_pc, 32'h100);
    chk("fw_first_word", instruction, word_of(32'h100));
    chk("fw_next_addr", imem_addr, 32'h104);

    // Flush coinciding with ack and pop at count 2.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fa_pre_addr", imem_addr, 32'h8);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("fa_valid0", 32'(instr_valid), 32'd0);
    chk("fa_addr", imem_addr, 32'h200);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fa_pc", instr_pc, 32'h200);
    chk("fa_word", instruction, word_of(32'h200));
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fa_empty", 32'(instr_valid), 32'd0);

    // PC wraps from 0xFFFF_FFFC to 0.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wr_held0", imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wr_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wr_wrap", imem_addr, 32'h0);
    chk("wr_pc", instr_pc, 32'hFFFF_FFFC);

    // Reset pulse while a request is pending and the queue holds data.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rm_req_pre", 32'(imem_req), 32'd1);
    chk("rm_valid_pre", 32'(instr_valid), 32'd1);
    #2;
    do_reset();
    chk("rm_restart_req", 32'(imem_req), 32'd1);
    chk("rm_restart_addr", imem_addr, 32'h0);
    chk("rm_restart_valid", 32'(instr_valid), 32'd0);

    // Randomized traffic against the queue-level model.
    begin
      int unsigned lat;
      int unsigned wait_cnt;
      bit          ack;
      bit          rdy;
      bit          fl;
      bit          acked;
      logic [31:0] fpc;

      do_reset();
      mq.delete();
      m_fetch_pc  = 32'h0;
      m_hold_addr = 32'h0;
      m_discard   = 1'b0;
      m_held      = 1'b0;
      lat         = 0;
      wait_cnt    = 0;
      for (int c = 0; c < 3000; c++) begin
        // A request is up whenever one is unaccepted or a free slot exists.
        m_req   = m_held || (mq.size() < DEPTH);
        m_addr  = m_discard ? m_hold_addr : m_fetch_pc;
        m_valid = (mq.size() != 0);
        chk("rnd_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("rnd_addr", imem_addr, m_addr);
        chk("rnd_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) begin
          chk("rnd_pc", instr_pc, mq[0].pc);
          chk("rnd_word", instruction, mq[0].word);
        end

        ack = 1'b0;
        if (imem_req) begin
          if (wait_cnt >= lat) begin
            ack      = 1'b1;
            wait_cnt = 0;
            lat      = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
        rdy = ($urandom_range(0, 99) < (((c / 400) % 2 == 0) ? 80 : 20));
        fl  = ($urandom_range(0, 99) < 4);
        fpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);

        acked = ack && m_req;
        if (fl) begin
          if (m_req && !acked) begin
            if (!m_discard) m_hold_addr = m_addr;
            m_discard = 1'b1;
          end else begin
            m_discard = 1'b0;
          end
          mq.delete();
          m_fetch_pc = fpc;
        end else begin
          if (m_valid && rdy) void'(mq.pop_front());
          if (acked) begin
            if (m_discard) begin
              m_discard = 1'b0;
            end else begin
              mq.push_back('{pc: m_fetch_pc, word: word_of(m_fetch_pc)});
              m_fetch_pc = m_fetch_pc + 32'd4;
            end
          end
        end
        m_held = m_req && !acked;

        step(ack, rdy, fl, fpc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
